// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
// The state encoding is one bit: IDLE arbitrates and BURST pops for one consumer.
// idx_width() returns an index width that is never zero, even when n <= 2.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width of a binary index into n items, at least 1 bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int MIN_BURST_LEN = 1;
  localparam int MIN_NUM_REQ   = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. The search starts just after last_id and
// wraps modulo NUM_REQ, so the previous winner has the lowest priority.
// found is low when no request bit is set; winner is 0 in that case.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_id,
  output logic [IW-1:0]      winner,
  output logic               found
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Walk the candidates last_id+1 .. last_id+NUM_REQ and keep the first requester
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_id) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter for the async FIFO read port, running in the R_CLK domain.
// It grants bounded bursts. Each pop returns data on the following cycle, and
// consecutive grants are separated by one idle cycle.
// A burst ends early when the granted consumer drops req or the FIFO goes empty.
// Optional per-consumer saturating pop counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          R_CLK,
  input  logic                          R_rst,
  input  logic                          R_empty,
  input  logic [DATA_WIDTH-1:0]         R_rdata,
  input  logic [NUM_REQ-1:0]            req,
  output logic                          R_inc,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  pop_cnt
`endif
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = idx_width(BURST_LEN);

  // Reject configurations that the burst counter and picker cannot represent
  if (BURST_LEN < MIN_BURST_LEN) begin : g_bad_burst
    $error("BURST_LEN must be at least 1");
  end
  if (NUM_REQ < MIN_NUM_REQ) begin : g_bad_req
    $error("NUM_REQ must be at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must be at least 1");
  end

  state_t        state, state_nxt;
  logic [IW-1:0] last_id;
  logic [IW-1:0] winner;
  logic          found;
  logic [BW-1:0] beat;
  logic          last_beat;
  logic          exit_burst;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .winner  (winner),
    .found   (found)
  );

  assign last_beat  = (beat == BW'(BURST_LEN - 1));
  // A burst ends on the last beat, when the owner drops req, or when the FIFO is empty
  assign exit_burst = (R_inc && last_beat) || !req[gnt_id] || R_empty;

  // State register
  always_ff @(posedge R_CLK or posedge R_rst) begin
    if (R_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: enter a burst only when someone requests and data is available
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found && !R_empty) state_nxt = BURST;
      BURST:   if (exit_burst)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state. The pop is gated by the registered empty flag only.
  always_comb begin
    busy  = (state == BURST);
    R_inc = busy & req[gnt_id] & ~R_empty;
  end

  // Grant, burst beat and round-robin history
  always_ff @(posedge R_CLK or posedge R_rst) begin
    if (R_rst) begin
      gnt     <= '0;
      gnt_id  <= '0;
      beat    <= '0;
      last_id <= IW'(NUM_REQ - 1);
    end else if (state == IDLE) begin
      if (state_nxt == BURST) begin
        gnt    <= NUM_REQ'(1) << winner;
        gnt_id <= winner;
        beat   <= '0;
      end
    end else begin
      if (R_inc) beat <= beat + 1'b1;
      if (exit_burst) begin
        gnt     <= '0;
        last_id <= gnt_id;
        beat    <= '0;
      end
    end
  end

  // Return the popped word to the granted consumer one cycle after the pop
  always_ff @(posedge R_CLK or posedge R_rst) begin
    if (R_rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else if (R_inc) begin
      rd_valid <= NUM_REQ'(1) << gnt_id;
      rd_data  <= R_rdata;
    end else begin
      rd_valid <= '0;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;

    // Count pops for consumer i and hold at all-ones instead of wrapping
    always_ff @(posedge R_CLK or posedge R_rst) begin
      if (R_rst)                                          cnt <= '0;
      else if (R_inc && (gnt_id == IW'(i)) && (cnt != '1)) cnt <= cnt + 1'b1;
    end

    assign pop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`else
  // No statistics hardware is built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          R_CLK = 1'b0;
  logic          R_rst;
  logic          R_empty;
  logic [DW-1:0] R_rdata;
  logic [NR-1:0] req;
  logic          R_inc;
  logic [NR-1:0] gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic [NR-1:0] rd_valid;
  logic [DW-1:0] rd_data;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*CW-1:0] pop_cnt;
`endif

  fifo_read_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .R_CLK(R_CLK), .R_rst(R_rst), .R_empty(R_empty), .R_rdata(R_rdata),
    .req(req), .R_inc(R_inc), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef FIFO_ARB_STATS_EN
    , .pop_cnt(pop_cnt)
`endif
  );

  always #5 R_CLK = ~R_CLK;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            gnt_log[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_valid_cyc = 0;
  logic [NR-1:0] prev_gnt = '0;

  // FIFO model: empty flag and head word change only after a clock edge
  task automatic refresh();
    R_empty = (fifo_q.size() == 0);
    R_rdata = R_empty ? '0 : fifo_q[0];
  endtask

  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
    refresh();
  endtask

  task automatic expect_words(input int id, input int n, input int base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id = id;
      e.d  = DW'(base + i);
      exp_q.push_back(e);
    end
  endtask

  function automatic bit log_matches(input int el[$]);
    if (gnt_log.size() != el.size()) return 1'b0;
    foreach (el[i]) if (gnt_log[i] != el[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample pop at negedge, advance, update FIFO model, score outputs
  task automatic tick();
    logic pend;
    @(negedge R_CLK);
    pend = R_inc;
    if (R_empty === 1'b1) begin
      checks++;
      if (R_inc !== 1'b0) begin
        failures++;
        $display("FAIL inc_while_empty: R_inc=%b required 0 at cycle %0d", R_inc, cyc);
      end
    end
    @(posedge R_CLK);
    #1;
    cyc++;
    if (pend === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
    checks++;
    if (!$onehot0(gnt)) begin
      failures++;
      $display("FAIL gnt_onehot: gnt=%b required one-hot or zero", gnt);
    end
    if (rd_valid !== '0) begin
      checks++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_data: rd_valid=%b rd_data=%h with nothing expected", rd_valid, rd_data);
      end else begin
        exp_t e = exp_q.pop_front();
        if (rd_valid !== (NR'(1) << e.id) || rd_data !== e.d) begin
          failures++;
          $display("FAIL data: rd_valid=%b rd_data=%h required rd_valid=%b rd_data=%h",
                   rd_valid, rd_data, NR'(1) << e.id, e.d);
        end
      end
    end
    if (gnt !== '0 && prev_gnt === '0)
      for (int k = 0; k < NR; k++) if (gnt[k]) gnt_log.push_back(k);
    prev_gnt = gnt;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    R_rst = 1'b1;
    req   = '0;
    fifo_q.delete();
    exp_q.delete();
    gnt_log.delete();
    refresh();
    @(posedge R_CLK);
    #1;
    R_rst    = 1'b0;
    prev_gnt = gnt;
  endtask

  task automatic test_reset();
    int el[$];
    R_rst = 1'b1;
    req   = '0;
    refresh();
    #1;
    checks++; if (gnt !== '0)      begin failures++; $display("FAIL rst_gnt: gnt=%b required 0", gnt); end
    checks++; if (gnt_id !== '0)   begin failures++; $display("FAIL rst_gnt_id: gnt_id=%0d required 0", gnt_id); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rst_busy: busy=%b required 0", busy); end
    checks++; if (R_inc !== 1'b0)  begin failures++; $display("FAIL rst_inc: R_inc=%b required 0", R_inc); end
    checks++; if (rd_valid !== '0) begin failures++; $display("FAIL rst_valid: rd_valid=%b required 0", rd_valid); end
    checks++; if (rd_data !== '0)  begin failures++; $display("FAIL rst_data: rd_data=%h required 0", rd_data); end
    @(posedge R_CLK);
    #1;
    R_rst = 1'b0;
    // Start a burst for consumer 0 and reset it after two pops
    write_words(8, 'hA0);
    req = 4'b0001;
    expect_words(0, 2, 'hA0);
    run(3);
    checks++;
    if (busy !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_burst_setup: busy=%b pending=%0d required busy=1 pending=0", busy, exp_q.size());
    end
    R_rst = 1'b1;
    #1;
    checks++;
    if (R_inc !== 1'b0 || gnt !== '0 || rd_valid !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_burst_reset: R_inc=%b gnt=%b rd_valid=%b busy=%b required all 0",
               R_inc, gnt, rd_valid, busy);
    end
    tick();
    R_rst = 1'b0;
    req   = 4'b1111;
    gnt_log.delete();
    prev_gnt = gnt;
    expect_words(0, 4, 'hA2);
    expect_words(1, 2, 'hA6);
    run(14);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_drain: pending=%0d required 0", exp_q.size());
    end
    el = '{0, 1};
    checks++;
    if (!log_matches(el)) begin
      failures++;
      $display("FAIL reset_first_grant: grants=%0d first=%0d required 2 grants starting 0",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int el[$];
    int start;
    do_reset();
    write_words(16, 0);
    for (int i = 0; i < 16; i++) expect_words(i / 4, 1, i);
    req   = 4'b1111;
    start = cyc;
    run(24);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_drain: pending=%0d required 0", exp_q.size());
    end
    checks++;
    if (last_valid_cyc - start != 20) begin
      failures++;
      $display("FAIL rr_throughput: last word at cycle %0d required 20", last_valid_cyc - start);
    end
    el = '{0, 1, 2, 3};
    checks++;
    if (!log_matches(el)) begin
      failures++;
      $display("FAIL rr_order: grants=%0d required order 0,1,2,3", gnt_log.size());
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (pop_cnt[i*CW +: CW] !== CW'(4)) begin
        failures++;
        $display("FAIL pop_cnt%0d: value=%0d required 4", i, pop_cnt[i*CW +: CW]);
      end
    end
`endif
    req = '0;
  endtask

  task automatic test_empty_term();
    int el[$];
    do_reset();
    write_words(2, 'h50);
    expect_words(2, 2, 'h50);
    req = 4'b0100;
    run(8);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_exit: pending=%0d busy=%b required 0 0", exp_q.size(), busy);
    end
    run(5);
    el = '{2};
    checks++;
    if (!log_matches(el) || gnt !== '0) begin
      failures++;
      $display("FAIL empty_no_regrant: grants=%0d gnt=%b required 1 grant and gnt 0", gnt_log.size(), gnt);
    end
    write_words(1, 'h60);
    expect_words(2, 1, 'h60);
    run(5);
    el = '{2, 2};
    checks++;
    if (exp_q.size() != 0 || !log_matches(el)) begin
      failures++;
      $display("FAIL empty_refill: pending=%0d grants=%0d required 0 pending, 2 grants", exp_q.size(), gnt_log.size());
    end
    req = '0;
  endtask

  task automatic test_req_drop();
    int el[$];
    do_reset();
    write_words(4, 'h70);
    expect_words(1, 1, 'h70);
    req = 4'b0010;
    run(2);
    req = 4'b0101;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      failures++;
      $display("FAIL drop_exit: busy=%b gnt=%b required 0 0", busy, gnt);
    end
    expect_words(2, 3, 'h71);
    run(8);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drop_drain: pending=%0d required 0", exp_q.size());
    end
    el = '{1, 2};
    checks++;
    if (!log_matches(el)) begin
      failures++;
      $display("FAIL drop_next_grant: grants=%0d second=%0d required 1 then 2",
               gnt_log.size(), (gnt_log.size() > 1) ? gnt_log[1] : -1);
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int el[$];
    do_reset();
    write_words(12, 'h80);
    expect_words(0, 4, 'h80);
    expect_words(3, 4, 'h84);
    expect_words(0, 4, 'h88);
    req = 4'b1001;
    run(20);
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      failures++;
      $display("FAIL fair_drain: pending=%0d fifo=%0d required 0 0", exp_q.size(), fifo_q.size());
    end
    el = '{0, 3, 0};
    checks++;
    if (!log_matches(el)) begin
      failures++;
      $display("FAIL fair_order: grants=%0d required order 0,3,0", gnt_log.size());
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_empty_term();
    test_req_drop();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
- Shares the read port of the asynchronous FIFO (read-pointer/empty logic in the R_CLK domain) between NUM_REQ consumers.
- Grants the port round-robin in bounded bursts and drives R_inc into the read-pointer block.
- Routes R_rdata back to the granted consumer with a registered valid strobe.
- Sits entirely in the read clock domain, between the FIFO read side and the consumers.

Parameters:
- NUM_REQ, 4, number of consumers (>=2).
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 4, maximum words popped per grant (>=1).
- CNT_WIDTH, 16, width of per-consumer statistics counters (optional feature only).

Ports:
- R_CLK  in  1  read-domain clock.
- R_rst  in  1  asynchronous, active-high reset.
- R_empty  in  1  registered empty flag from the FIFO read pointer.
- R_rdata  in  DATA_WIDTH  FIFO word at the current read address; valid in the same cycle.
- req  in  NUM_REQ  per-consumer read request, level.
- R_inc  out  1  pop strobe to the read pointer.
- gnt  out  NUM_REQ  one-hot registered grant.
- gnt_id  out  $clog2(NUM_REQ)  binary index of the grant; valid while busy.
- busy  out  1  high in BURST state.
- rd_valid  out  NUM_REQ  one-hot registered data strobe.
- rd_data  out  DATA_WIDTH  registered popped word.

Behaviour:
- Reset (asynchronous, any cycle, including mid-burst):
  - state=IDLE; gnt=0, gnt_id=0, busy=0, R_inc=0, rd_valid=0, rd_data=0, beat=0.
  - last_id=NUM_REQ-1, so consumer 0 has first priority.
  - An in-flight burst is abandoned; no pop occurs in the reset cycle.
- IDLE:
  - R_inc=0.
  - If |req and !R_empty: winner = first set req searching from last_id+1 upward, wrapping modulo NUM_REQ.
  - Next edge: gnt=onehot(winner), gnt_id=winner, beat=0, state=BURST.
  - Otherwise stay in IDLE.
- BURST:
  - R_inc = req[gnt_id] & ~R_empty, combinational. It is never asserted while R_empty=1.
  - On each pop: beat++ and rd_valid[gnt_id]<=1, rd_data<=R_rdata on the next edge. Pop-to-data latency is 1 cycle.
  - Non-pop cycles: rd_valid<=0 and rd_data holds.
- BURST exit to IDLE on the next edge when any of the following holds:
  - a pop with beat==BURST_LEN-1;
  - req[gnt_id]==0;
  - R_empty==1.
- On exit:
  - gnt<=0, busy<=0, last_id<=gnt_id.
  - The beat count is discarded; a requester re-entering starts a fresh burst.
- Arbitration bubble: one IDLE cycle between consecutive grants. Sustained throughput with all requesting and FIFO non-empty is BURST_LEN/(BURST_LEN+1) words/cycle.
- Simultaneous conditions:
  - The last beat coinciding with R_empty going high still counts as one pop; a single exit.
  - A req change on non-granted lines during BURST has no effect until the next IDLE.
- R_empty is only used as the registered flag; no combinational path from R_inc back to the empty computation inside this block.
- rd_valid is always one-hot or zero; gnt is always one-hot or zero.

Optional Feature:
- FIFO_ARB_STATS_EN defined:
  - Adds output pop_cnt, NUM_REQ*CNT_WIDTH bits. Slice i counts pops granted to consumer i.
  - Counters reset to 0 on R_rst, increment on R_inc with gnt_id==i, and saturate at all-ones.
- Not defined: no counters, no port, and identical timing on all other outputs.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}, 1-bit encoding;
  - localparam function for the $clog2 index width;
  - BURST_LEN minimum check constant.
- Sub-module rr_pick:
  - combinational round-robin picker;
  - inputs: req vector and last_id;
  - outputs: winner index and found flag.
  - Instantiated once.

Test Plan:
- Reset value check: assert R_rst mid-burst (beat=2) -> same cycle R_inc=0, gnt=0, rd_valid=0; after release consumer 0 is granted first when req=4'b1111.
- Round-robin burst order: req=4'b1111, FIFO holds 16 words, BURST_LEN=4 -> grants 0,1,2,3 in order. Each consumer receives 4 consecutive rd_valid pulses, with words 0-3, 4-7, 8-11, 12-15 in order. One idle cycle between bursts.
- Empty termination: FIFO holds 2 words, req=4'b0100 -> consumer 2 gets 2 words, then returns to IDLE. R_inc never high while R_empty=1; no further grant until a write raises !R_empty.
- Requester drop: req[1] deasserted after 1 pop of a grant to consumer 1 -> exactly 1 word delivered, exit next edge. The following grant goes to consumer 2 (last_id=1), not to 0.
- Fairness/wrap: req=4'b1001 with last_id=3 -> grant 0, then 3, then 0. No consumer is skipped or granted twice consecutively while the other requests.
- With FIFO_ARB_STATS_EN: run the round-robin scenario -> pop_cnt slices all read 4. Preload counter to all-ones minus 1, then pop 3 -> counter saturates at all-ones.
